// File: rtl/car_motion.sv
// car_motion: per-frame player-car game logic.
//   Advances once per video frame (rising edge of vs) and produces the car
//   position, speed, road scroll offset, distance score and game state.
// Ports:
//   Clk        system clock
//   Reset      synchronous, active-high
//   vs         VGA vsync (active-low pulse), already in the Clk domain
//   keycode_0  HID keycode slot 0 (0x00 = none)
//   keycode_1  HID keycode slot 1
//   CarX       car left X pixel
//   CarY       fixed car Y pixel
//   Speed      rows per frame
//   ScrollY    road scroll offset, 0..SCREEN_H-1
//   Score      distance score, saturating
//   State      00 IDLE, 01 RUN, 10 CRASH
//   Crash      high while in CRASH
module car_motion #(
  parameter int ROAD_L       = 160,
  parameter int ROAD_R       = 480,
  parameter int CAR_W        = 32,
  parameter int CAR_Y        = 400,
  parameter int STEER_STEP   = 4,
  parameter int MAX_SPEED    = 15,
  parameter int CRASH_FRAMES = 120,
  parameter int SCREEN_H     = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  output logic [9:0] CarX,
  output logic [9:0] CarY,
  output logic [3:0] Speed,
  output logic [8:0] ScrollY,
  output logic [15:0] Score,
  output logic [1:0] State,
  output logic       Crash
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_CRASH = 2'b10
  } state_e;

  localparam logic [10:0] L_W     = 11'(ROAD_L);
  localparam logic [10:0] R_W     = 11'(ROAD_R);
  localparam logic [10:0] CW_W    = 11'(CAR_W);
  localparam logic [10:0] STEP_W  = 11'(STEER_STEP);
  localparam logic [9:0]  X_CTR   = 10'((ROAD_L + ROAD_R - CAR_W) / 2);
  localparam logic [9:0]  X_LCLMP = 10'(ROAD_L);
  localparam logic [9:0]  X_RCLMP = 10'(ROAD_R - CAR_W);
  localparam logic [3:0]  SPD_MAX = 4'(MAX_SPEED);
  localparam logic [7:0]  CF_W    = 8'(CRASH_FRAMES);
  localparam logic [9:0]  SH_W    = 10'(SCREEN_H);

  // registered state
  state_e      state_q;
  logic        vs_q;
  logic        crash_q;
  logic [9:0]  carx_q;
  logic [3:0]  speed_q;
  logic [8:0]  scroll_q;
  logic [15:0] score_q;
  logic [7:0]  ccnt_q;
  logic [2:0]  coast_q;

  // frame tick on vs rising edge
  logic tick;
  assign tick = vs & ~vs_q;

  // key decode: a key counts if it is in either slot
  function automatic logic key_hit(input logic [7:0] k0, input logic [7:0] k1,
                                   input logic [7:0] code);
    return (k0 == code) || (k1 == code);
  endfunction

  logic k_left, k_right, k_accel, k_brake, k_start;
  assign k_left  = key_hit(keycode_0, keycode_1, 8'h04) | key_hit(keycode_0, keycode_1, 8'h50);
  assign k_right = key_hit(keycode_0, keycode_1, 8'h07) | key_hit(keycode_0, keycode_1, 8'h4F);
  assign k_accel = key_hit(keycode_0, keycode_1, 8'h1A) | key_hit(keycode_0, keycode_1, 8'h52);
  assign k_brake = key_hit(keycode_0, keycode_1, 8'h16) | key_hit(keycode_0, keycode_1, 8'h51);
  assign k_start = key_hit(keycode_0, keycode_1, 8'h2C);

  // RUN-state candidate values for the current tick
  logic [3:0]  speed_d;
  logic [2:0]  coast_d;
  logic [10:0] nx;
  logic [9:0]  carx_d;
  logic        wall_hit;
  logic [9:0]  ssum;
  logic [9:0]  swrap;
  logic [8:0]  scroll_d;
  logic [16:0] score_sum;
  logic [15:0] score_d;

  always_comb begin
    speed_d = speed_q;
    coast_d = coast_q;
    // brake dominates accel when both are held
    if (k_brake) begin
      speed_d = (speed_q >= 4'd2) ? speed_q - 4'd2 : 4'd0;
    end else if (k_accel) begin
      speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 4'd1;
    end else begin
      // coasting sheds one unit every 8th coasting tick
      coast_d = coast_q + 3'd1;
      if (coast_q == 3'd7 && speed_q != 4'd0) speed_d = speed_q - 4'd1;
    end

    nx = {1'b0, carx_q};
    if (speed_d != 4'd0) begin
      if (k_left && !k_right)      nx = {1'b0, carx_q} - STEP_W;
      else if (k_right && !k_left) nx = {1'b0, carx_q} + STEP_W;
    end

    wall_hit = 1'b0;
    carx_d   = nx[9:0];
    if (nx < L_W) begin
      carx_d   = X_LCLMP;
      wall_hit = 1'b1;
    end else if (nx + CW_W > R_W) begin
      carx_d   = X_RCLMP;
      wall_hit = 1'b1;
    end

    ssum     = {1'b0, scroll_q} + {6'd0, speed_d};
    swrap    = ssum - SH_W;
    scroll_d = (ssum >= SH_W) ? swrap[8:0] : ssum[8:0];

    score_sum = {1'b0, score_q} + {13'd0, speed_d};
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      vs_q     <= 1'b1;
      crash_q  <= 1'b0;
      carx_q   <= X_CTR;
      speed_q  <= 4'd0;
      scroll_q <= 9'd0;
      score_q  <= 16'd0;
      ccnt_q   <= 8'd0;
      coast_q  <= 3'd0;
    end else begin
      vs_q <= vs;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            speed_q <= 4'd0;
            if (k_start) begin
              state_q <= S_RUN;
              score_q <= 16'd0;
              carx_q  <= X_CTR;
            end
          end
          S_RUN: begin
            coast_q <= coast_d;
            carx_q  <= carx_d;
            if (wall_hit) begin
              // crash tick freezes scroll and score
              state_q <= S_CRASH;
              crash_q <= 1'b1;
              speed_q <= 4'd0;
              ccnt_q  <= CF_W;
            end else begin
              speed_q  <= speed_d;
              scroll_q <= scroll_d;
              score_q  <= score_d;
            end
          end
          S_CRASH: begin
            if (ccnt_q <= 8'd1) begin
              state_q <= S_IDLE;
              crash_q <= 1'b0;
              ccnt_q  <= 8'd0;
              carx_q  <= X_CTR;
            end else begin
              ccnt_q <= ccnt_q - 8'd1;
            end
          end
          default: begin
            // unreachable encoding: fall back to a clean IDLE
            state_q <= S_IDLE;
            crash_q <= 1'b0;
            speed_q <= 4'd0;
            ccnt_q  <= 8'd0;
          end
        endcase
      end
    end
  end

  assign CarX    = carx_q;
  assign CarY    = 10'(CAR_Y);
  assign Speed   = speed_q;
  assign ScrollY = scroll_q;
  assign Score   = score_q;
  assign State   = state_q;
  assign Crash   = crash_q;

endmodule

// File: tb/tb_car_motion.sv
// Directed bench for car_motion: reset, start/accel, scroll wrap, steering
// and wall crashes on both sides, brake/coast, reset priority, stuck vsync.
module tb_car_motion;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        vs;
  logic [7:0]  keycode_0, keycode_1;
  logic [9:0]  CarX, CarY;
  logic [3:0]  Speed;
  logic [8:0]  ScrollY;
  logic [15:0] Score;
  logic [1:0]  State;
  logic        Crash;

  int n_chk  = 0;
  int n_pass = 0;

  car_motion dut (
    .Clk(Clk), .Reset(Reset), .vs(vs),
    .keycode_0(keycode_0), .keycode_1(keycode_1),
    .CarX(CarX), .CarY(CarY), .Speed(Speed), .ScrollY(ScrollY),
    .Score(Score), .State(State), .Crash(Crash)
  );

  always #10 Clk = ~Clk;

  // one frame: vs low for a cycle, then rising; sample on the negedge after
  task automatic tick();
    @(negedge Clk) vs = 1'b0;
    @(negedge Clk) vs = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; vs = 1'b1; keycode_0 = 8'h00; keycode_1 = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_chk++; if (CarX !== 10'd304) $display("FAIL reset_carx got %0d want 304", CarX); else n_pass++;
    n_chk++; if (CarY !== 10'd400) $display("FAIL reset_cary got %0d want 400", CarY); else n_pass++;
    n_chk++; if (Speed !== 4'd0) $display("FAIL reset_speed got %0d want 0", Speed); else n_pass++;
    n_chk++; if (ScrollY !== 9'd0) $display("FAIL reset_scroll got %0d want 0", ScrollY); else n_pass++;
    n_chk++; if (Score !== 16'd0) $display("FAIL reset_score got %0d want 0", Score); else n_pass++;
    n_chk++; if (State !== 2'b00) $display("FAIL reset_state got %0d want 0", State); else n_pass++;
    n_chk++; if (Crash !== 1'b0) $display("FAIL reset_crash got %0d want 0", Crash); else n_pass++;
  endtask

  task automatic test_start_accel();
    logic [3:0] exp_s;
    keycode_0 = 8'h2C;
    tick();
    n_chk++; if (State !== 2'b01) $display("FAIL start_state got %0d want 1", State); else n_pass++;
    n_chk++; if (Speed !== 4'd0) $display("FAIL start_speed got %0d want 0", Speed); else n_pass++;
    keycode_0 = 8'h00; keycode_1 = 8'h1A;
    for (int f = 1; f <= 20; f++) begin
      tick();
      exp_s = (f > 15) ? 4'd15 : 4'(f);
      n_chk++; if (Speed !== exp_s) $display("FAIL accel_f%0d got %0d want %0d", f, Speed, exp_s); else n_pass++;
    end
    // 1+..+15 + 5*15
    n_chk++; if (ScrollY !== 9'd195) $display("FAIL accel_scroll got %0d want 195", ScrollY); else n_pass++;
    n_chk++; if (Score !== 16'd195) $display("FAIL accel_score got %0d want 195", Score); else n_pass++;
  endtask

  task automatic test_scroll_wrap();
    repeat (18) tick();
    n_chk++; if (ScrollY !== 9'd465) $display("FAIL wrap_pre got %0d want 465", ScrollY); else n_pass++;
    tick();
    n_chk++; if (ScrollY !== 9'd0) $display("FAIL wrap_at_480 got %0d want 0", ScrollY); else n_pass++;
    n_chk++; if (Score !== 16'd480) $display("FAIL wrap_score got %0d want 480", Score); else n_pass++;
    tick();
    n_chk++; if (ScrollY !== 9'd15) $display("FAIL wrap_post got %0d want 15", ScrollY); else n_pass++;
  endtask

  task automatic test_steer_both();
    keycode_0 = 8'h04; keycode_1 = 8'h07;
    tick();
    n_chk++; if (CarX !== 10'd304) $display("FAIL both_steer_carx got %0d want 304", CarX); else n_pass++;
    n_chk++; if (Speed !== 4'd15) $display("FAIL both_steer_speed got %0d want 15", Speed); else n_pass++;
    n_chk++; if (ScrollY !== 9'd30) $display("FAIL both_steer_scroll got %0d want 30", ScrollY); else n_pass++;
  endtask

  task automatic test_brake();
    keycode_0 = 8'h00; keycode_1 = 8'h16;
    for (int f = 1; f <= 5; f++) begin
      tick();
      n_chk++; if (Speed !== 4'(15 - 2 * f)) $display("FAIL brake_f%0d got %0d want %0d", f, Speed, 15 - 2 * f); else n_pass++;
    end
    keycode_0 = 8'h1A;
    tick();
    n_chk++; if (Speed !== 4'd3) $display("FAIL brake_over_accel got %0d want 3", Speed); else n_pass++;
    keycode_0 = 8'h00;
    tick();
    n_chk++; if (Speed !== 4'd1) $display("FAIL brake_to1 got %0d want 1", Speed); else n_pass++;
    tick();
    n_chk++; if (Speed !== 4'd0) $display("FAIL brake_floor got %0d want 0", Speed); else n_pass++;
    n_chk++; if (ScrollY !== 9'd79) $display("FAIL brake_scroll got %0d want 79", ScrollY); else n_pass++;
    keycode_1 = 8'h00;
    tick();
    n_chk++; if (ScrollY !== 9'd79) $display("FAIL idle_speed0_scroll got %0d want 79", ScrollY); else n_pass++;
    n_chk++; if (Score !== 16'd559) $display("FAIL idle_speed0_score got %0d want 559", Score); else n_pass++;
  endtask

  task automatic test_steer_right();
    keycode_0 = 8'h07; keycode_1 = 8'h1A;
    tick();
    n_chk++; if (CarX !== 10'd308) $display("FAIL right_f1 got %0d want 308", CarX); else n_pass++;
    repeat (35) tick();
    n_chk++; if (CarX !== 10'd448) $display("FAIL right_f36 got %0d want 448", CarX); else n_pass++;
    n_chk++; if (State !== 2'b01) $display("FAIL right_f36_state got %0d want 1", State); else n_pass++;
    tick();
    n_chk++; if (CarX !== 10'd448) $display("FAIL right_clamp got %0d want 448", CarX); else n_pass++;
    n_chk++; if (Speed !== 4'd0) $display("FAIL right_crash_speed got %0d want 0", Speed); else n_pass++;
    n_chk++; if (State !== 2'b10) $display("FAIL right_crash_state got %0d want 2", State); else n_pass++;
    n_chk++; if (Crash !== 1'b1) $display("FAIL right_crash_flag got %0d want 1", Crash); else n_pass++;
    n_chk++; if (ScrollY !== 9'd34) $display("FAIL right_crash_scroll got %0d want 34", ScrollY); else n_pass++;
    n_chk++; if (Score !== 16'd994) $display("FAIL right_crash_score got %0d want 994", Score); else n_pass++;
    repeat (119) tick();
    n_chk++; if (State !== 2'b10) $display("FAIL crash_t119_state got %0d want 2", State); else n_pass++;
    n_chk++; if (Score !== 16'd994) $display("FAIL crash_hold_score got %0d want 994", Score); else n_pass++;
    tick();
    n_chk++; if (State !== 2'b00) $display("FAIL crash_end_state got %0d want 0", State); else n_pass++;
    n_chk++; if (CarX !== 10'd304) $display("FAIL crash_end_carx got %0d want 304", CarX); else n_pass++;
    n_chk++; if (Crash !== 1'b0) $display("FAIL crash_end_flag got %0d want 0", Crash); else n_pass++;
  endtask

  task automatic test_steer_left();
    keycode_0 = 8'h2C; keycode_1 = 8'h00;
    tick();
    n_chk++; if (Score !== 16'd0) $display("FAIL restart_score got %0d want 0", Score); else n_pass++;
    keycode_0 = 8'h04; keycode_1 = 8'h52;
    repeat (36) tick();
    n_chk++; if (CarX !== 10'd160) $display("FAIL left_f36 got %0d want 160", CarX); else n_pass++;
    n_chk++; if (Score !== 16'd435) $display("FAIL left_f36_score got %0d want 435", Score); else n_pass++;
    tick();
    n_chk++; if (CarX !== 10'd160) $display("FAIL left_clamp got %0d want 160", CarX); else n_pass++;
    n_chk++; if (State !== 2'b10) $display("FAIL left_crash_state got %0d want 2", State); else n_pass++;
    // start held through the crash: first tick back in IDLE must restart
    keycode_0 = 8'h2C; keycode_1 = 8'h00;
    repeat (120) tick();
    n_chk++; if (State !== 2'b00) $display("FAIL held_start_idle got %0d want 0", State); else n_pass++;
    tick();
    n_chk++; if (State !== 2'b01) $display("FAIL held_start_run got %0d want 1", State); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    keycode_0 = 8'h1A;
    tick(); tick();
    n_chk++; if (Speed !== 4'd2) $display("FAIL pre_reset_speed got %0d want 2", Speed); else n_pass++;
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    n_chk++; if (Speed !== 4'd0) $display("FAIL midrun_reset_speed got %0d want 0", Speed); else n_pass++;
    n_chk++; if (State !== 2'b00) $display("FAIL midrun_reset_state got %0d want 0", State); else n_pass++;
    n_chk++; if (ScrollY !== 9'd0) $display("FAIL midrun_reset_scroll got %0d want 0", ScrollY); else n_pass++;
    keycode_0 = 8'h2C; tick();
    keycode_0 = 8'h1A; tick();
    n_chk++; if (Score !== 16'd1) $display("FAIL pre_coinc_score got %0d want 1", Score); else n_pass++;
    @(negedge Clk) vs = 1'b0;
    @(negedge Clk) begin vs = 1'b1; Reset = 1'b1; end
    @(negedge Clk) Reset = 1'b0;
    n_chk++; if (Speed !== 4'd0) $display("FAIL coinc_reset_speed got %0d want 0", Speed); else n_pass++;
    n_chk++; if (Score !== 16'd0) $display("FAIL coinc_reset_score got %0d want 0", Score); else n_pass++;
    n_chk++; if (State !== 2'b00) $display("FAIL coinc_reset_state got %0d want 0", State); else n_pass++;
  endtask

  task automatic test_vs_stuck();
    keycode_0 = 8'h2C; tick();
    keycode_0 = 8'h1A; tick();
    repeat (50) @(negedge Clk);
    n_chk++; if (Speed !== 4'd1) $display("FAIL vs_high_speed got %0d want 1", Speed); else n_pass++;
    n_chk++; if (ScrollY !== 9'd1) $display("FAIL vs_high_scroll got %0d want 1", ScrollY); else n_pass++;
    vs = 1'b0;
    repeat (50) @(negedge Clk);
    n_chk++; if (Score !== 16'd1) $display("FAIL vs_low_score got %0d want 1", Score); else n_pass++;
    vs = 1'b1;
    @(negedge Clk);
    n_chk++; if (Speed !== 4'd2) $display("FAIL vs_resume_speed got %0d want 2", Speed); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_start_accel();
    test_scroll_wrap();
    test_steer_both();
    test_brake();
    test_steer_right();
    test_steer_left();
    test_reset_mid_run();
    test_vs_stuck();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
